// File: rtl/clahe_pkg.sv
// Shared types and helpers for the CLAHE tile scheduler.
package clahe_pkg;

  // Calc sequencer states: wait for a frame, issue one tile, wait for the engine, swap LUT banks
  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_ISSUE = 2'd1,
    C_WAIT  = 2'd2,
    C_SWAP  = 2'd3
  } calc_state_e;

  // Width of a packed {tile_y, tile_x} index for a BLOCK x BLOCK tile grid
  function automatic int tile_idx_w(input int block);
    return 2 * $clog2(block);
  endfunction

endpackage

// File: rtl/clahe_tile_sched_if.sv
// Pixel-tagging and calc-engine handshake bundle for clahe_tile_sched.
interface clahe_tile_sched_if #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int BLOCK  = 8
);
  import clahe_pkg::*;

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int TB  = $clog2(BLOCK);
  localparam int CTW = tile_idx_w(BLOCK);

  logic           src_valid;
  logic           src_last;
  logic           coord_valid;
  logic [XW-1:0]  pix_x;
  logic [YW-1:0]  pix_y;
  logic [TB-1:0]  tile_x;
  logic [TB-1:0]  tile_y;
  logic           hist_bank;
  logic           frame_end;
  logic           calc_start;
  logic [CTW-1:0] calc_tile;
  logic           calc_bank;
  logic           calc_done;
  logic           lut_bank;
  logic           lut_ready;
  logic           overrun;
  logic           frame_err;

  // Pixel source and calc engine side
  modport master (
    output src_valid, src_last, calc_done,
    input  coord_valid, pix_x, pix_y, tile_x, tile_y, hist_bank, frame_end,
    input  calc_start, calc_tile, calc_bank, lut_bank, lut_ready, overrun, frame_err
  );

  // Scheduler side
  modport slave (
    input  src_valid, src_last, calc_done,
    output coord_valid, pix_x, pix_y, tile_x, tile_y, hist_bank, frame_end,
    output calc_start, calc_tile, calc_bank, lut_bank, lut_ready, overrun, frame_err
  );

endinterface

// File: rtl/clahe_raster_cnt.sv
// Raster position tracker: tags each pixel with x/y and tile coordinates, detects frame end.
module clahe_raster_cnt #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int BLOCK  = 8,
  localparam int XW    = $clog2(WIDTH),
  localparam int YW    = $clog2(HEIGHT),
  localparam int TB    = $clog2(BLOCK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_valid,
  input  logic          src_last,
  output logic          coord_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [TB-1:0] tile_x,
  output logic [TB-1:0] tile_y,
  output logic          frame_end,
  output logic          frame_err,
  output logic          frame_end_evt
);

  localparam int TW = WIDTH / BLOCK;
  localparam int TH = HEIGHT / BLOCK;
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [XW-1:0] XS_LAST = XW'(TW - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] YS_LAST = YW'(TH - 1);

  logic [XW-1:0] x_q, x_d, xs_q, xs_d;
  logic [YW-1:0] y_q, y_d, ys_q, ys_d;
  logic [TB-1:0] tx_q, tx_d, ty_q, ty_d;
  logic          coord_valid_q, coord_valid_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic [TB-1:0] tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic          frame_end_q, frame_end_d;
  logic          frame_err_q, frame_err_d;
  logic          last_pix;
  logic          end_evt;

  // Tag the current pixel, then advance the counters; xs/ys sub-counters step the tile index without a divider
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    xs_d          = xs_q;
    ys_d          = ys_q;
    tx_d          = tx_q;
    ty_d          = ty_q;
    coord_valid_d = src_valid;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    frame_end_d   = 1'b0;
    frame_err_d   = frame_err_q;
    last_pix      = (x_q == X_LAST) && (y_q == Y_LAST);
    end_evt       = src_valid && (last_pix || src_last);

    if (src_valid) begin
      pix_x_d     = x_q;
      pix_y_d     = y_q;
      tile_x_d    = tx_q;
      tile_y_d    = ty_q;
      frame_end_d = end_evt;
      if (end_evt) begin
        x_d  = '0;
        y_d  = '0;
        xs_d = '0;
        ys_d = '0;
        tx_d = '0;
        ty_d = '0;
        if (last_pix != src_last) frame_err_d = 1'b1;
      end else if (x_q == X_LAST) begin
        x_d  = '0;
        xs_d = '0;
        tx_d = '0;
        y_d  = y_q + YW'(1);
        if (ys_q == YS_LAST) begin
          ys_d = '0;
          ty_d = ty_q + TB'(1);
        end else begin
          ys_d = ys_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
        if (xs_q == XS_LAST) begin
          xs_d = '0;
          tx_d = tx_q + TB'(1);
        end else begin
          xs_d = xs_q + XW'(1);
        end
      end
    end
  end

  // Register counters and tagged outputs; frame_err is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      xs_q          <= '0;
      ys_q          <= '0;
      tx_q          <= '0;
      ty_q          <= '0;
      coord_valid_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      xs_q          <= xs_d;
      ys_q          <= ys_d;
      tx_q          <= tx_d;
      ty_q          <= ty_d;
      coord_valid_q <= coord_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      frame_end_q   <= frame_end_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign coord_valid   = coord_valid_q;
  assign pix_x         = pix_x_q;
  assign pix_y         = pix_y_q;
  assign tile_x        = tile_x_q;
  assign tile_y        = tile_y_q;
  assign frame_end     = frame_end_q;
  assign frame_err     = frame_err_q;
  assign frame_end_evt = end_evt;

endmodule

// File: rtl/clahe_tile_sched.sv
// CLAHE frame/tile scheduler: raster tagging, ping-pong bank control and per-tile calc sequencing.
module clahe_tile_sched
  import clahe_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int BLOCK  = 8,
  localparam int CTW   = tile_idx_w(BLOCK)
) (
  input  logic        clk,
  input  logic        rst,
  clahe_tile_sched_if.slave bus
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int TB = $clog2(BLOCK);
  localparam logic [CTW-1:0] TILE_LAST = CTW'(BLOCK * BLOCK - 1);

  logic          coord_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [TB-1:0] tile_x, tile_y;
  logic          frame_end, frame_err, end_evt;

  clahe_raster_cnt #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .BLOCK (BLOCK)
  ) u_raster (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (bus.src_valid),
    .src_last     (bus.src_last),
    .coord_valid  (coord_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .frame_end    (frame_end),
    .frame_err    (frame_err),
    .frame_end_evt(end_evt)
  );

  calc_state_e    state_q, state_d;
  logic [CTW-1:0] calc_tile_q, calc_tile_d;
  logic           calc_bank_q, calc_bank_d;
  logic           calc_start_q, calc_start_d;
  logic           lut_bank_q, lut_bank_d;
  logic           lut_ready_q, lut_ready_d;
  logic           overrun_q, overrun_d;
  logic           hist_bank_q, hist_bank_d;
  logic           req_q, req_d;
  logic           busy;

  // Next-state for the calc sequencer; a frame end while a sequence is live or pending is dropped as an overrun
  always_comb begin
    state_d      = state_q;
    calc_tile_d  = calc_tile_q;
    calc_bank_d  = calc_bank_q;
    calc_start_d = 1'b0;
    lut_bank_d   = lut_bank_q;
    lut_ready_d  = lut_ready_q;
    overrun_d    = overrun_q;
    hist_bank_d  = hist_bank_q;
    req_d        = req_q;
    busy         = (state_q == C_ISSUE) || (state_q == C_WAIT) ||
                   ((state_q == C_IDLE) && req_q);

    case (state_q)
      C_IDLE: begin
        if (req_q) begin
          req_d        = 1'b0;
          state_d      = C_ISSUE;
          calc_tile_d  = '0;
          calc_bank_d  = ~hist_bank_q;
          calc_start_d = 1'b1;
        end
      end
      C_ISSUE: begin
        state_d = C_WAIT;
      end
      C_WAIT: begin
        if (bus.calc_done) begin
          if (calc_tile_q == TILE_LAST) begin
            state_d     = C_SWAP;
            lut_bank_d  = ~lut_bank_q;
            lut_ready_d = 1'b1;
          end else begin
            state_d      = C_ISSUE;
            calc_tile_d  = calc_tile_q + CTW'(1);
            calc_start_d = 1'b1;
          end
        end
      end
      C_SWAP: begin
        state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase

    if (end_evt) begin
      hist_bank_d = ~hist_bank_q;
      if (busy) overrun_d = 1'b1;
      else      req_d     = 1'b1;
    end
  end

  // Sequencer state and its registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= C_IDLE;
      calc_tile_q  <= '0;
      calc_bank_q  <= 1'b0;
      calc_start_q <= 1'b0;
      lut_bank_q   <= 1'b0;
      lut_ready_q  <= 1'b0;
      overrun_q    <= 1'b0;
      hist_bank_q  <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      calc_tile_q  <= calc_tile_d;
      calc_bank_q  <= calc_bank_d;
      calc_start_q <= calc_start_d;
      lut_bank_q   <= lut_bank_d;
      lut_ready_q  <= lut_ready_d;
      overrun_q    <= overrun_d;
      hist_bank_q  <= hist_bank_d;
      req_q        <= req_d;
    end
  end

  assign bus.coord_valid = coord_valid;
  assign bus.pix_x       = pix_x;
  assign bus.pix_y       = pix_y;
  assign bus.tile_x      = tile_x;
  assign bus.tile_y      = tile_y;
  assign bus.frame_end   = frame_end;
  assign bus.frame_err   = frame_err;
  assign bus.hist_bank   = hist_bank_q;
  assign bus.calc_start  = calc_start_q;
  assign bus.calc_tile   = calc_tile_q;
  assign bus.calc_bank   = calc_bank_q;
  assign bus.lut_bank    = lut_bank_q;
  assign bus.lut_ready   = lut_ready_q;
  assign bus.overrun     = overrun_q;

endmodule
